// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop input synchroniser, start/data/parity/stop decoding with
// frame and parity error detection, feeding a first-word-fall-through receive FIFO.
module uart_rx_fifo #(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        mclk,
    input  logic                        reset_n,
    input  logic                        rx,
    output logic [DATA_BITS-1:0]        rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic                        frame_err,
    output logic                        parity_err,
    output logic                        overrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        busy
);
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned LW   = AW + 1;
    localparam int unsigned CW   = $clog2(CLK_DIV + 1);
    localparam int unsigned BW   = $clog2(DATA_BITS + 1);
    localparam int unsigned HALF = (CLK_DIV / 2 < 1) ? 1 : CLK_DIV / 2;
    localparam logic        PAR_ODD = 1'(PARITY_ODD);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HI
    } state_t;

    state_t               state, state_n;
    logic                 rx_meta, rx_s, rx_prev;
    logic [CW-1:0]        cnt, cnt_n;
    logic [BW-1:0]        bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 par_bad, par_bad_n;
    logic                 stop_bad, stop_bad_n;
    logic                 frame_err_n, parity_err_n;
    logic                 tick_c, push_c, pop_c, full_c, wr_en_c;
    logic [LW-1:0]        level_n;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;

    // Input synchroniser plus one extra stage for falling-edge detection
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign tick_c = (cnt == CW'(1));

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bad    <= 1'b0;
            stop_bad   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_cnt    <= bit_cnt_n;
            shreg      <= shreg_n;
            par_bad    <= par_bad_n;
            stop_bad   <= stop_bad_n;
            frame_err  <= frame_err_n;
            parity_err <= parity_err_n;
            busy       <= (state_n != S_IDLE);
        end
    end

    // Frame decoder: every sampling state reloads a full bit period on tick
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        bit_cnt_n    = bit_cnt;
        shreg_n      = shreg;
        par_bad_n    = par_bad;
        stop_bad_n   = stop_bad;
        frame_err_n  = 1'b0;
        parity_err_n = 1'b0;
        push_c       = 1'b0;
        case (state)
            S_IDLE: begin
                if (rx_prev && !rx_s) begin
                    cnt_n   = CW'(HALF);
                    state_n = S_START;
                end
            end
            S_START: begin
                if (!tick_c) begin
                    cnt_n = cnt - CW'(1);
                end else if (rx_s) begin
                    state_n = S_IDLE;
                end else begin
                    state_n    = S_DATA;
                    cnt_n      = CW'(CLK_DIV);
                    bit_cnt_n  = '0;
                    par_bad_n  = 1'b0;
                    stop_bad_n = 1'b0;
                end
            end
            S_DATA: begin
                if (!tick_c) begin
                    cnt_n = cnt - CW'(1);
                end else begin
                    cnt_n     = CW'(CLK_DIV);
                    shreg_n   = {rx_s, shreg[DATA_BITS-1:1]};
                    bit_cnt_n = bit_cnt + BW'(1);
                    if (bit_cnt == BW'(DATA_BITS - 1)) begin
                        bit_cnt_n = '0;
                        state_n   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (!tick_c) begin
                    cnt_n = cnt - CW'(1);
                end else begin
                    cnt_n     = CW'(CLK_DIV);
                    par_bad_n = rx_s ^ (^shreg) ^ PAR_ODD;
                    state_n   = S_STOP;
                end
            end
            S_STOP: begin
                if (!tick_c) begin
                    cnt_n = cnt - CW'(1);
                end else begin
                    cnt_n = CW'(CLK_DIV);
                    if (bit_cnt == BW'(STOP_BITS - 1)) begin
                        if (stop_bad || !rx_s) begin
                            frame_err_n = 1'b1;
                            state_n     = S_WAIT_HI;
                        end else if (par_bad) begin
                            parity_err_n = 1'b1;
                            state_n      = S_IDLE;
                        end else begin
                            push_c  = 1'b1;
                            state_n = S_IDLE;
                        end
                    end else begin
                        bit_cnt_n  = bit_cnt + BW'(1);
                        stop_bad_n = stop_bad | ~rx_s;
                    end
                end
            end
            S_WAIT_HI: begin
                if (rx_s) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // A simultaneous pop frees the slot, so a push into a full FIFO still lands
    assign pop_c   = rx_valid & rx_ready;
    assign full_c  = (fifo_level == LW'(FIFO_DEPTH));
    assign wr_en_c = push_c & (~full_c | pop_c);
    assign rx_data = mem[rd_ptr];

    always_comb begin
        level_n = fifo_level;
        case ({wr_en_c, pop_c})
            2'b10:   level_n = fifo_level + LW'(1);
            2'b01:   level_n = fifo_level - LW'(1);
            default: level_n = fifo_level;
        endcase
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            rx_valid   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (wr_en_c) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_c) rd_ptr <= rd_ptr + AW'(1);
            fifo_level <= level_n;
            rx_valid   <= (level_n != '0);
            overrun    <= push_c & full_c & ~pop_c;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8N1 CLK_DIV=2 instance and an 8O1 CLK_DIV=16 instance.
module tb_uart_rx_fifo;
    localparam int DIV   = 2;
    localparam int DIV_P = 16;
    localparam int DEPTH = 4;

    logic       mclk = 1'b0;
    logic       reset_n;
    logic       rx, rx_p, rx_ready, rx_ready_p;
    logic [7:0] rx_data, rx_data_p;
    logic       rx_valid, frame_err, parity_err, overrun, busy;
    logic       rx_valid_p, frame_err_p, parity_err_p, overrun_p, busy_p;
    logic [2:0] fifo_level, fifo_level_p;

    int n_checks = 0;
    int n_fail   = 0;
    int fe_cnt = 0, pe_cnt = 0, ov_cnt = 0, fe_cnt_p = 0, pe_cnt_p = 0;

    typedef struct {
        logic [7:0] data;
        logic       stop_val;
        int         exp_level;
        int         exp_fe;
    } vec_t;

    always #5 mclk = ~mclk;

    uart_rx_fifo #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                   .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut (
        .mclk(mclk), .reset_n(reset_n), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .frame_err(frame_err), .parity_err(parity_err),
        .overrun(overrun), .fifo_level(fifo_level), .busy(busy));

    uart_rx_fifo #(.CLK_DIV(DIV_P), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1),
                   .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_p (
        .mclk(mclk), .reset_n(reset_n), .rx(rx_p), .rx_data(rx_data_p), .rx_valid(rx_valid_p),
        .rx_ready(rx_ready_p), .frame_err(frame_err_p), .parity_err(parity_err_p),
        .overrun(overrun_p), .fifo_level(fifo_level_p), .busy(busy_p));

    // Pulse counters sampled mid-cycle; each one-cycle pulse counts once
    always @(negedge mclk) begin
        if (frame_err)    fe_cnt++;
        if (parity_err)   pe_cnt++;
        if (overrun)      ov_cnt++;
        if (frame_err_p)  fe_cnt_p++;
        if (parity_err_p) pe_cnt_p++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rx_p = v;
        else     rx   = v;
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] data, input bit has_par,
                              input logic par_bit, input logic stop_val);
        logic [10:0] f;
        int n;
        int div;
        div = sel ? DIV_P : DIV;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = data[i];
        n = 9;
        if (has_par) begin
            f[n] = par_bit;
            n++;
        end
        f[n] = stop_val;
        n++;
        for (int b = 0; b < n; b++) begin
            drive(sel, f[b]);
            repeat (div) @(negedge mclk);
        end
    endtask

    task automatic idle(input bit sel, input int bits);
        drive(sel, 1'b1);
        repeat (bits * (sel ? DIV_P : DIV) + 4) @(negedge mclk);
    endtask

    task automatic pop_check(input bit sel, input string name, input logic [7:0] exp);
        if (sel) begin
            check({name, "_valid"}, 32'(rx_valid_p), 32'(1));
            check(name, 32'(rx_data_p), 32'(exp));
            rx_ready_p = 1'b1;
            @(negedge mclk);
            rx_ready_p = 1'b0;
        end else begin
            check({name, "_valid"}, 32'(rx_valid), 32'(1));
            check(name, 32'(rx_data), 32'(exp));
            rx_ready = 1'b1;
            @(negedge mclk);
            rx_ready = 1'b0;
        end
    endtask

    initial begin
        vec_t       vecs [6];
        logic [7:0] q [$];
        logic [7:0] w;
        logic       bad;
        int         fe0, pe0, ov0, nbusy, nfr, exp_fe, exp_ov;

        vecs[0] = '{8'h00, 1'b1, 1, 0};
        vecs[1] = '{8'hFF, 1'b1, 1, 0};
        vecs[2] = '{8'h5A, 1'b1, 1, 0};
        vecs[3] = '{8'hA5, 1'b0, 0, 1};
        vecs[4] = '{8'h81, 1'b1, 1, 0};
        vecs[5] = '{8'h7E, 1'b0, 0, 1};

        reset_n = 1'b0; rx = 1'b1; rx_p = 1'b1; rx_ready = 1'b0; rx_ready_p = 1'b0;
        repeat (3) @(negedge mclk);
        reset_n = 1'b1;
        @(negedge mclk);
        check("rst_level",   32'(fifo_level),   32'(0));
        check("rst_valid",   32'(rx_valid),     32'(0));
        check("rst_busy",    32'(busy),         32'(0));
        check("rst_data",    32'(rx_data),      32'(0));
        check("rst_errs",    32'({frame_err, parity_err, overrun}), 32'(0));
        check("rst_level_p", 32'(fifo_level_p), 32'(0));

        // Single-frame vectors
        for (int k = 0; k < 6; k++) begin
            fe0 = fe_cnt;
            send_frame(0, vecs[k].data, 0, 1'b0, vecs[k].stop_val);
            idle(0, 3);
            check($sformatf("vec%0d_level", k), 32'(fifo_level), 32'(vecs[k].exp_level));
            check($sformatf("vec%0d_fe", k), 32'(fe_cnt - fe0), 32'(vecs[k].exp_fe));
            if (vecs[k].exp_level == 1) pop_check(0, $sformatf("vec%0d_data", k), vecs[k].data);
        end

        // Back-to-back frames
        send_frame(0, 8'h55, 0, 1'b0, 1'b1);
        send_frame(0, 8'hA3, 0, 1'b0, 1'b1);
        idle(0, 3);
        check("b2b_level", 32'(fifo_level), 32'(2));
        pop_check(0, "b2b_first", 8'h55);
        pop_check(0, "b2b_second", 8'hA3);
        check("b2b_empty", 32'(fifo_level), 32'(0));

        // One-cycle glitch on idle line
        fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt; nbusy = 0;
        rx = 1'b0;
        @(negedge mclk);
        rx = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge mclk);
            if (busy) nbusy++;
        end
        check("glitch_busy_len_ok", 32'(nbusy >= 1 && nbusy <= DIV), 32'(1));
        check("glitch_busy_end", 32'(busy), 32'(0));
        check("glitch_level", 32'(fifo_level), 32'(0));
        check("glitch_pulses", 32'((fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0)), 32'(0));

        // Bad stop bit, recovery with next frame
        fe0 = fe_cnt;
        send_frame(0, 8'hA5, 0, 1'b0, 1'b0);
        idle(0, 3);
        check("fe_count", 32'(fe_cnt - fe0), 32'(1));
        check("fe_level", 32'(fifo_level), 32'(0));
        send_frame(0, 8'h3C, 0, 1'b0, 1'b1);
        idle(0, 3);
        pop_check(0, "fe_recover", 8'h3C);

        // Held-low break gives exactly one frame error
        fe0 = fe_cnt;
        rx = 1'b0;
        repeat (40) @(negedge mclk);
        check("break_busy", 32'(busy), 32'(1));
        idle(0, 3);
        check("break_fe", 32'(fe_cnt - fe0), 32'(1));
        check("break_idle", 32'(busy), 32'(0));

        // Overrun on fifth word
        ov0 = ov_cnt;
        for (int k = 1; k <= 5; k++) begin
            send_frame(0, 8'(k), 0, 1'b0, 1'b1);
            idle(0, 1);
        end
        idle(0, 2);
        check("ovr_count", 32'(ov_cnt - ov0), 32'(1));
        check("ovr_level", 32'(fifo_level), 32'(DEPTH));
        for (int k = 1; k <= 4; k++) pop_check(0, $sformatf("ovr_pop%0d", k), 8'(k));
        check("ovr_empty", 32'(fifo_level), 32'(0));

        // Odd parity instance: expected parity bit computed from the data
        pe0 = pe_cnt_p;
        send_frame(1, 8'h07, 1, 1'b0, 1'b1);
        idle(1, 2);
        check("par_ok_level", 32'(fifo_level_p), 32'(1));
        pop_check(1, "par_ok_data", 8'h07);
        send_frame(1, 8'h07, 1, 1'b1, 1'b1);
        idle(1, 2);
        check("par_bad_pe", 32'(pe_cnt_p - pe0), 32'(1));
        check("par_bad_level", 32'(fifo_level_p), 32'(0));
        for (int k = 0; k < 3; k++) begin
            w = 8'($urandom);
            send_frame(1, w, 1, ~(^w), 1'b1);
            idle(1, 2);
            pop_check(1, $sformatf("par_rand%0d", k), w);
        end
        check("par_fe_none", 32'(fe_cnt_p), 32'(0));

        // Randomised batches against a queue model of depth DEPTH
        for (int bt = 0; bt < 5; bt++) begin
            q.delete();
            exp_fe = 0; exp_ov = 0;
            fe0 = fe_cnt; ov0 = ov_cnt;
            nfr = int'($urandom_range(3, 7));
            for (int k = 0; k < nfr; k++) begin
                w   = 8'($urandom);
                bad = ($urandom_range(0, 4) == 0);
                send_frame(0, w, 0, 1'b0, ~bad);
                idle(0, 2);
                if (bad)                  exp_fe++;
                else if (q.size() < DEPTH) q.push_back(w);
                else                       exp_ov++;
            end
            check($sformatf("rnd%0d_fe", bt), 32'(fe_cnt - fe0), 32'(exp_fe));
            check($sformatf("rnd%0d_ov", bt), 32'(ov_cnt - ov0), 32'(exp_ov));
            check($sformatf("rnd%0d_level", bt), 32'(fifo_level), 32'(q.size()));
            while (q.size() > 0) pop_check(0, $sformatf("rnd%0d_pop", bt), q.pop_front());
        end

        // Reset in the middle of a frame
        send_frame(0, 8'h11, 0, 1'b0, 1'b1);
        idle(0, 3);
        check("mid_pre_level", 32'(fifo_level), 32'(1));
        rx = 1'b0;
        repeat (DIV) @(negedge mclk);
        rx = 1'b1;
        repeat (3 * DIV) @(negedge mclk);
        check("mid_busy", 32'(busy), 32'(1));
        reset_n = 1'b0;
        #1;
        check("mid_rst_level", 32'(fifo_level), 32'(0));
        check("mid_rst_valid", 32'(rx_valid), 32'(0));
        check("mid_rst_busy",  32'(busy), 32'(0));
        check("mid_rst_data",  32'(rx_data), 32'(0));
        repeat (2) @(negedge mclk);
        reset_n = 1'b1;
        @(negedge mclk);
        send_frame(0, 8'h42, 0, 1'b0, 1'b1);
        idle(0, 3);
        check("mid_after_level", 32'(fifo_level), 32'(1));
        pop_check(0, "mid_after_data", 8'h42);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
